// File: rtl/sys_seg_pkg.sv
// ============================================================================
// Module  : sys_seg_pkg
// Brief   : Shared constants for the seven-segment scan back-end.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package sys_seg_pkg;

    localparam int SEG_NUM_DIGITS = 8;
    localparam int SEG_MAX_DIGITS = 8;

    typedef logic [6:0] seg_cat_t;

    localparam seg_cat_t SEG_CAT_OFF = 7'h7F;
    localparam logic [SEG_MAX_DIGITS-1:0] SEG_AN_OFF = '1;

    // Active-low {g,f,e,d,c,b,a}; entry 15 first so that index == nibble
    localparam logic [15:0][6:0] SEG_HEX_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    function automatic seg_cat_t hex_to_seg(input logic [3:0] nibble);
        return SEG_HEX_TABLE[nibble];
    endfunction

endpackage

`default_nettype wire

// File: rtl/sys_hex7seg.sv
// ============================================================================
// Module  : sys_hex7seg
// Brief   : Combinational hex nibble to active-low seven-segment decoder.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sys_hex7seg
    import sys_seg_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    assign o_seg = hex_to_seg(i_nibble);

endmodule

`default_nettype wire

// File: rtl/sys_seg_scan.sv
// ============================================================================
// Module  : sys_seg_scan
// Brief   : Multiplexed 8-digit seven-segment scanner with frame-synchronous
//           double buffering and exception blink.
//           Build option SEG_BLANK_LZ_EN enables leading-zero blanking.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sys_seg_scan
    import sys_seg_pkg::*;
#(
    parameter int DIV_W      = 16,
    parameter int NUM_DIGITS = SEG_NUM_DIGITS,
    parameter int BLINK_W    = 6
) (
    input  logic                  SYS_clk,
    input  logic                  SYS_reset,
    input  logic [31:0]           SEG_value,
    input  logic                  SEG_load,
    input  logic                  SEG_exc,
    output logic [NUM_DIGITS-1:0] SEG_an,
    output logic [6:0]            SEG_cat,
    output logic                  SEG_dp,
    output logic                  SEG_pending
);

    localparam int c_DIG_W = 3;
    localparam logic [c_DIG_W-1:0] c_LAST_DIG = c_DIG_W'(NUM_DIGITS - 1);

    logic [DIV_W-1:0]          r_div_cnt;
    logic [c_DIG_W-1:0]        r_dig;
    logic [BLINK_W-1:0]        r_frame_cnt;
    logic [31:0]               r_shadow;
    logic [31:0]               r_disp;
    logic                      r_pending;
    logic                      r_exc;
    logic [NUM_DIGITS-1:0]     r_an;
    logic [6:0]                r_cat;
    logic                      r_dp;

    logic                      w_tick;
    logic                      w_frame_start;
    logic [3:0]                w_nibble;
    logic [6:0]                w_cat;
    logic [NUM_DIGITS-1:0]     w_an_scan;
    logic [SEG_MAX_DIGITS-1:0] w_lz_mask;
    logic                      w_blank;

    assign w_tick        = &r_div_cnt;
    assign w_frame_start = w_tick && (r_dig == c_LAST_DIG);

    always_ff @(posedge SYS_clk) begin
        if (SYS_reset) begin
            r_div_cnt   <= '0;
            r_dig       <= '0;
            r_frame_cnt <= '0;
            r_shadow    <= '0;
            r_disp      <= '0;
            r_pending   <= 1'b0;
            r_exc       <= 1'b0;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
            r_exc     <= SEG_exc;
            if (w_tick) begin
                r_dig <= (r_dig == c_LAST_DIG) ? '0 : r_dig + 1'b1;
            end
            if (w_frame_start) begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end
            // Commit takes the shadow as it was before any same-cycle load
            if (w_frame_start && r_pending) begin
                r_disp <= r_shadow;
            end
            if (SEG_load) begin
                r_shadow  <= SEG_value;
                r_pending <= 1'b1;
            end else if (w_frame_start) begin
                r_pending <= 1'b0;
            end
        end
    end

    assign w_nibble = r_disp[{r_dig, 2'b00} +: 4];

    sys_hex7seg u_hex7seg (
        .i_nibble (w_nibble),
        .o_seg    (w_cat)
    );

`ifdef SEG_BLANK_LZ_EN
    logic w_zero_run;

    // Walk down from the top digit; a digit is blankable while all above it are zero
    always_comb begin
        w_lz_mask  = '0;
        w_zero_run = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            w_zero_run   = w_zero_run && (r_disp[4*k +: 4] == 4'h0);
            w_lz_mask[k] = w_zero_run;
        end
    end
`else
    assign w_lz_mask = '0;
`endif

    assign w_an_scan = ~(NUM_DIGITS'(1) << r_dig);
    assign w_blank   = (r_exc && r_frame_cnt[BLINK_W-1]) || w_lz_mask[r_dig];

    always_ff @(posedge SYS_clk) begin
        if (SYS_reset) begin
            r_an  <= SEG_AN_OFF[NUM_DIGITS-1:0];
            r_cat <= SEG_CAT_OFF;
            r_dp  <= 1'b1;
        end else begin
            r_an  <= w_blank ? SEG_AN_OFF[NUM_DIGITS-1:0] : w_an_scan;
            r_cat <= w_cat;
            r_dp  <= ~((r_dig == '0) && r_pending);
        end
    end

    assign SEG_an      = r_an;
    assign SEG_cat     = r_cat;
    assign SEG_dp      = r_dp;
    assign SEG_pending = r_pending;

endmodule

`default_nettype wire

// File: tb/tb_sys_seg_scan.sv
// ============================================================================
// Module  : tb_sys_seg_scan
// Brief   : Self-checking bench for sys_seg_scan (DIV_W=2, BLINK_W=1, 8 digits).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sys_seg_scan;

    localparam int DIV_W      = 2;
    localparam int NUM_DIGITS = 8;
    localparam int BLINK_W    = 1;
`ifdef SEG_BLANK_LZ_EN
    localparam bit LZ_EN = 1'b1;
`else
    localparam bit LZ_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        SYS_reset = 1'b1;
    logic [31:0] SEG_value = '0;
    logic        SEG_load = 1'b0;
    logic        SEG_exc = 1'b0;
    logic [7:0]  SEG_an;
    logic [6:0]  SEG_cat;
    logic        SEG_dp;
    logic        SEG_pending;

    always #5 clk = ~clk;

    sys_seg_scan #(
        .DIV_W      (DIV_W),
        .NUM_DIGITS (NUM_DIGITS),
        .BLINK_W    (BLINK_W)
    ) dut (
        .SYS_clk     (clk),
        .SYS_reset   (SYS_reset),
        .SEG_value   (SEG_value),
        .SEG_load    (SEG_load),
        .SEG_exc     (SEG_exc),
        .SEG_an      (SEG_an),
        .SEG_cat     (SEG_cat),
        .SEG_dp      (SEG_dp),
        .SEG_pending (SEG_pending)
    );

    typedef struct {
        int          ph;
        int          at;
        logic [31:0] val;
        logic        ld;
        logic        exc;
    } stim_t;

    typedef struct {
        int          ph;
        int          base;
        logic [31:0] disp;
        logic        blink;
        int          plo;
        int          phi;
    } frame_t;

    typedef struct {
        int          ph;
        int          at;
        logic [31:0] disp;
        logic        blink;
        logic        pend;
    } hand_t;

    typedef struct {
        int         at;
        logic [7:0] an;
        logic [6:0] cat;
        logic       dp;
        logic       pend;
        logic       chk_cat;
    } chk_t;

    stim_t  stim_tab[11];
    frame_t frame_tab[8];
    hand_t  hand_tab[14];
    stim_t  stim_q[$];
    chk_t   chk_q[$];

    int n;
    int n_tests = 0;
    int n_fail  = 0;

    function automatic logic [6:0] hex7(input logic [3:0] d);
        case (d)
            4'h0: return 7'h40;  4'h1: return 7'h79;
            4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;
            4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;
            4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;
            4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    // Expected outputs registered at edge e, given the committed value and flags
    task automatic push_chk(input int e, input logic [31:0] disp,
                            input logic blink, input logic pend);
        chk_t c;
        int   k;
        int   i;
        logic blank;
        k     = (e >> DIV_W) % NUM_DIGITS;
        blank = blink;
        if (LZ_EN && k > 0 && (disp >> (4 * k)) == 32'h0) blank = 1'b1;
        c.at      = e;
        c.an      = blank ? 8'hFF : ~(8'h01 << k);
        c.cat     = hex7(disp[4*k +: 4]);
        c.dp      = !(k == 0 && pend);
        c.pend    = pend;
        c.chk_cat = !blank;
        i = 0;
        while (i < chk_q.size() && chk_q[i].at <= e) i++;
        chk_q.insert(i, c);
    endtask

    task automatic load_phase(input int ph);
        for (int i = 0; i < 11; i++)
            if (stim_tab[i].ph == ph) stim_q.push_back(stim_tab[i]);
        for (int i = 0; i < 8; i++) begin
            if (frame_tab[i].ph == ph) begin
                for (int k = 0; k < NUM_DIGITS; k++) begin
                    int e;
                    e = frame_tab[i].base + 4 * k + 1;
                    push_chk(e, frame_tab[i].disp, frame_tab[i].blink,
                             (e >= frame_tab[i].plo) && (e < frame_tab[i].phi));
                end
            end
        end
        for (int i = 0; i < 14; i++)
            if (hand_tab[i].ph == ph)
                push_chk(hand_tab[i].at, hand_tab[i].disp, hand_tab[i].blink, hand_tab[i].pend);
    endtask

    task automatic run_to(input int last);
        stim_t s;
        chk_t  c;
        while (n <= last) begin
            @(negedge clk);
            SEG_load = 1'b0;
            if (stim_q.size() > 0 && stim_q[0].at == n) begin
                s = stim_q.pop_front();
                SEG_load  = s.ld;
                SEG_value = s.val;
                SEG_exc   = s.exc;
            end
            @(posedge clk);
            #1;
            while (chk_q.size() > 0 && chk_q[0].at == n) begin
                c = chk_q.pop_front();
                n_tests++;
                if (SEG_an !== c.an || (c.chk_cat && SEG_cat !== c.cat) ||
                    SEG_dp !== c.dp || SEG_pending !== c.pend) begin
                    n_fail++;
                    $display("FAIL seg_out e%0d: got an=%h cat=%h dp=%b pend=%b, want an=%h cat=%h dp=%b pend=%b",
                             n, SEG_an, SEG_cat, SEG_dp, SEG_pending, c.an, c.cat, c.dp, c.pend);
                end
            end
            n++;
        end
        while (chk_q.size() > 0) begin
            c = chk_q.pop_front();
            n_tests++;
            n_fail++;
            $display("FAIL seg_out e%0d: got no sample, want an=%h cat=%h", c.at, c.an, c.cat);
        end
    endtask

    task automatic check_reset(input int tag);
        n_tests++;
        if (SEG_an !== 8'hFF || SEG_cat !== 7'h7F || SEG_dp !== 1'b1 || SEG_pending !== 1'b0) begin
            n_fail++;
            $display("FAIL reset%0d: got an=%h cat=%h dp=%b pend=%b, want an=ff cat=7f dp=1 pend=0",
                     tag, SEG_an, SEG_cat, SEG_dp, SEG_pending);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //            ph  at   value         ld    exc
        stim_tab[0]  = '{0,   1, 32'h1234ABCD, 1'b1, 1'b0};
        stim_tab[1]  = '{0,  40, 32'h11111111, 1'b1, 1'b0};
        stim_tab[2]  = '{0,  50, 32'h22222222, 1'b1, 1'b0};
        stim_tab[3]  = '{0,  90, 32'h00000005, 1'b1, 1'b0};
        stim_tab[4]  = '{0,  95, 32'h0000000F, 1'b1, 1'b0};
        stim_tab[5]  = '{0, 150, 32'hDEADBEEF, 1'b1, 1'b0};
        stim_tab[6]  = '{1,   1, 32'h76543210, 1'b1, 1'b0};
        stim_tab[7]  = '{1,  32, 32'h00000000, 1'b0, 1'b1};
        stim_tab[8]  = '{1, 100, 32'h00000000, 1'b0, 1'b0};
        stim_tab[9]  = '{1, 130, 32'h000000A0, 1'b1, 1'b0};
        stim_tab[10] = '{1, 170, 32'h00000000, 1'b1, 1'b0};

        //             ph base  shown         blink pend window
        frame_tab[0] = '{0,  32, 32'h1234ABCD, 1'b0,  40,  63};
        frame_tab[1] = '{0,  64, 32'h22222222, 1'b0,  90, 127};
        frame_tab[2] = '{0,  96, 32'h00000005, 1'b0,  90, 127};
        frame_tab[3] = '{0, 128, 32'h0000000F, 1'b0, 150, 191};
        frame_tab[4] = '{1,  32, 32'h76543210, 1'b1,   0,   0};
        frame_tab[5] = '{1,  64, 32'h76543210, 1'b0,   0,   0};
        frame_tab[6] = '{1, 160, 32'h000000A0, 1'b0, 170, 191};
        frame_tab[7] = '{1, 192, 32'h00000000, 1'b0,   0,   0};

        //            ph  at  shown         blink pend
        hand_tab[0]  = '{0,   0, 32'h00000000, 1'b0, 1'b0};
        hand_tab[1]  = '{0,   2, 32'h00000000, 1'b0, 1'b1};
        hand_tab[2]  = '{0,  30, 32'h00000000, 1'b0, 1'b1};
        hand_tab[3]  = '{0,  31, 32'h00000000, 1'b0, 1'b0};
        hand_tab[4]  = '{0,  95, 32'h22222222, 1'b0, 1'b1};
        hand_tab[5]  = '{0, 126, 32'h00000005, 1'b0, 1'b1};
        hand_tab[6]  = '{0, 127, 32'h00000005, 1'b0, 1'b0};
        hand_tab[7]  = '{1,   0, 32'h00000000, 1'b0, 1'b0};
        hand_tab[8]  = '{1,   2, 32'h00000000, 1'b0, 1'b1};
        hand_tab[9]  = '{1,  32, 32'h76543210, 1'b0, 1'b0};
        hand_tab[10] = '{1,  97, 32'h76543210, 1'b1, 1'b0};
        hand_tab[11] = '{1, 100, 32'h76543210, 1'b1, 1'b0};
        hand_tab[12] = '{1, 101, 32'h76543210, 1'b0, 1'b0};
        hand_tab[13] = '{1, 105, 32'h76543210, 1'b0, 1'b0};

        // Power-on reset, then the buffering and coincident-commit sequences
        repeat (3) @(posedge clk);
        #1;
        check_reset(0);
        SYS_reset = 1'b0;
        n = 0;
        load_phase(0);
        run_to(160);

        // Reset mid-scan with a load still pending; both buffers must be dropped
        SYS_reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset(1);
        SYS_reset = 1'b0;
        n = 0;
        load_phase(1);
        run_to(225);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
